// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary decode path.
// Holds the converter state encoding and the nibble correction constants.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIGIT_W    = 4;
  localparam int ADJ_THRESH = 8;
  localparam int ADJ_VAL    = 3;

  // Smallest binary width whose range covers every value of a DIGITS-digit BCD number.
  function automatic int min_bin_w(input int digits);
    longint unsigned lim;
    int w;
    lim = 1;
    w   = 0;
    for (int i = 0; i < digits; i++) begin
      lim = lim * 10;
    end
    while ((longint'(1) << w) < lim) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd2bin_sub3.sv
// Combinational nibble corrector for reverse double-dabble:
// a digit that reads 8 or more after the right shift loses 3.
module sub3
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] in,
  output logic [DIGIT_W-1:0] out
);

  assign out = (in >= DIGIT_W'(ADJ_THRESH)) ? in - DIGIT_W'(ADJ_VAL) : in;

endmodule

// File: rtl/bcd2bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble, one shift per clock).
// Optional invalid-digit checking is enabled by defining BCD2BIN_CHECK_EN.
//
// Handshake: start is sampled only while idle (busy low); an accepted start
// latches in. done is a one-cycle pulse when out (and err) become valid;
// out holds until the next accepted start. start while busy is dropped.
module bcd2bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      out,
  output logic                  err,
  output state_t                dbg_state
);

  localparam int BCD_W  = DIGIT_W * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  state_t            state;
  logic [WORK_W-1:0] work;
  logic [WORK_W-1:0] shifted;
  logic [WORK_W-1:0] next_work;
  logic [CNT_W-1:0]  cnt;

  assign dbg_state = state;

  // Binary bits fall out of the bottom of the BCD field one per shift.
  assign shifted = work >> 1;
  assign next_work[BIN_W-1:0] = shifted[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    sub3 u_sub3 (
      .in  (shifted[BIN_W + g*DIGIT_W +: DIGIT_W]),
      .out (next_work[BIN_W + g*DIGIT_W +: DIGIT_W])
    );
  end

`ifdef BCD2BIN_CHECK_EN
  logic invalid;
  logic bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (in[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(9)) begin
        bad_digit = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
      work  <= '0;
      cnt   <= '0;
`ifdef BCD2BIN_CHECK_EN
      invalid <= 1'b0;
      err     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work  <= {in, {BIN_W{1'b0}}};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
`ifdef BCD2BIN_CHECK_EN
            invalid <= bad_digit;
            err     <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          work <= next_work;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            done  <= 1'b1;
`ifdef BCD2BIN_CHECK_EN
            out <= invalid ? '0 : next_work[BIN_W-1:0];
            err <= invalid;
`else
            out <= next_work[BIN_W-1:0];
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

`ifndef BCD2BIN_CHECK_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin.sv
// Self-checking bench for bcd2bin: vector table, handshake corner cases,
// mid-conversion reset and back-to-back random conversions against a decimal model.
module tb_bcd2bin;
  import bcd_pkg::*;

  localparam int DIGITS = 4;
  localparam int BIN_W  = min_bin_w(DIGITS);
  localparam int LAT    = BIN_W + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [15:0]      in;
  logic             busy;
  logic             done;
  logic [BIN_W-1:0] out;
  logic             err;
  state_t           dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0]      in;
    logic [BIN_W-1:0] exp_out;
    logic             exp_err;
    bit               chk_out;
  } vec_t;

  vec_t vecs[$];

  bcd2bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in        (in),
    .busy      (busy),
    .done      (done),
    .out       (out),
    .err       (err),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Decimal value of a packed BCD word, digit 0 in the low nibble.
  function automatic int bcd_value(input logic [15:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      r = r * 10 + int'(v[i*4 +: 4]);
    end
    return r;
  endfunction

  // Waits for done; lat counts the start cycle, so a nominal run gives LAT.
  task automatic wait_done(input logic [BIN_W-1:0] prev, output int lat, output bit early);
    lat   = -1;
    early = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k + 1;
        break;
      end
      if (out !== prev) early = 1'b1;
    end
  endtask

  task automatic convert(input logic [15:0] v, output logic [BIN_W-1:0] o, output logic e);
    logic [BIN_W-1:0] prev;
    int lat;
    bit early;
    @(negedge clk);
    start = 1'b1;
    in    = v;
    @(posedge clk); #1;
    start = 1'b0;
    prev  = out;
    check("busy_after_start", 32'(busy), 32'd1);
    wait_done(prev, lat, early);
    check("out_stable_while_busy", 32'(early), 32'd0);
    check("latency", lat, LAT);
    o = out;
    e = err;
    @(posedge clk); #1;
    check("done_single_pulse", 32'(done), 32'd0);
    check("busy_low_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [BIN_W-1:0] o;
    logic             e;
    logic [15:0]      v;
    int               lat;
    bit               early;
    bit               seen_done;

    vecs.push_back('{16'h9999, BIN_W'(9999), 1'b0, 1'b1});
    vecs.push_back('{16'h0000, BIN_W'(0),    1'b0, 1'b1});
    vecs.push_back('{16'h1234, BIN_W'(1234), 1'b0, 1'b1});
    vecs.push_back('{16'h0001, BIN_W'(1),    1'b0, 1'b1});
    vecs.push_back('{16'h5678, BIN_W'(5678), 1'b0, 1'b1});
    vecs.push_back('{16'h1000, BIN_W'(1000), 1'b0, 1'b1});
    vecs.push_back('{16'h0999, BIN_W'(999),  1'b0, 1'b1});
`ifdef BCD2BIN_CHECK_EN
    vecs.push_back('{16'h12A4, BIN_W'(0),    1'b1, 1'b1});
    vecs.push_back('{16'h0042, BIN_W'(42),   1'b0, 1'b1});
    vecs.push_back('{16'hF009, BIN_W'(0),    1'b1, 1'b1});
`else
    vecs.push_back('{16'h12A4, BIN_W'(0),    1'b0, 1'b0});
    vecs.push_back('{16'h0042, BIN_W'(42),   1'b0, 1'b1});
`endif

    rst   = 1'b1;
    start = 1'b0;
    in    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_out", 32'(out), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      convert(vecs[i].in, o, e);
      if (vecs[i].chk_out) check($sformatf("vec%0d_out", i), 32'(o), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
    end

    // start held through the whole conversion: only the idle-cycle start counts.
    @(negedge clk);
    start = 1'b1;
    in    = 16'h1234;
    @(posedge clk); #1;
    in = 16'h0001;
    check("hold_state_shift", 32'(dbg_state), 32'(SHIFT));
    wait_done(out, lat, early);
    check("hold_latency", lat, LAT);
    check("hold_first_out", 32'(out), 32'd1234);
    @(posedge clk); #1;
    check("hold_ignored_in_done", 32'(busy), 32'd0);
    check("hold_idle_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;
    start = 1'b0;
    check("hold_second_accept", 32'(busy), 32'd1);
    check("hold_out_kept", 32'(out), 32'd1234);
    wait_done(out, lat, early);
    check("hold_second_latency", lat, LAT);
    check("hold_second_out", 32'(out), 32'd1);
    @(posedge clk); #1;

    // Reset during the seventh shift aborts with no done pulse.
    @(negedge clk);
    start = 1'b1;
    in    = 16'h5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_out", 32'(out), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    seen_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done) seen_done = 1'b1;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    convert(16'h5678, o, e);
    check("abort_recover_out", 32'(o), 32'd5678);

    // Back-to-back random valid BCD, next start in the first idle cycle.
    for (int n = 0; n < 100; n++) begin
      v = '0;
      for (int d = 0; d < DIGITS; d++) v[d*4 +: 4] = 4'($urandom_range(0, 9));
      convert(v, o, e);
      check($sformatf("rand%0d_out_%04h", n, v), 32'(o), bcd_value(v));
      check($sformatf("rand%0d_err", n), 32'(e), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
